// File: rtl/fifo_burst_drainer.sv
// -----------------------------------------------------------------------------
// fifo_burst_drainer
//
// Read-side consumer for a synchronous show-ahead FIFO. Words are popped from
// the FIFO, passed through a one-word hold register (H) and an output register
// (O), and presented downstream as a valid/ready stream framed into bursts.
//
// H is a look-behind stage. A word's "last" flag can only be decided once it is
// known whether another word follows it. So a word waits in H until one of the
// following happens:
//   - the next word is present in the FIFO (not last), or
//   - the burst reaches BURST_LEN beats (last), or
//   - the FIFO stays empty for IDLE_TIMEOUT cycles (last), or
//   - flush is asserted (last).
//
// Parameters:
//   WIDTH        data word width (matches the FIFO)
//   BURST_LEN    maximum beats per burst (>=1)
//   IDLE_TIMEOUT idle cycles (>=1) before a held word is released as burst end
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   fifo_rd_en     pop strobe to the FIFO (combinational)
//   fifo_rd_data   FIFO head word (show-ahead)
//   fifo_empty     FIFO empty flag
//   m_valid        output beat valid
//   m_ready        downstream ready
//   m_data         output beat data
//   m_last         final beat of the burst
//   flush          level; force-closes the open burst
//   busy           hold or output register occupied
//   bursts_sent    count of completed bursts (last-beat handshakes); wraps
// -----------------------------------------------------------------------------
module fifo_burst_drainer #(
  parameter int WIDTH        = 64,
  parameter int BURST_LEN    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             flush,
  output logic             busy,
  output logic [31:0]      bursts_sent
);

  // A one-beat burst still needs a (constant zero) beat counter.
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  // The idle counter must be able to hold IDLE_TIMEOUT itself.
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             h_valid_q, h_valid_d;
  logic [WIDTH-1:0] h_data_q,  h_data_d;

  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_data_q,  o_data_d;
  logic             o_last_q,  o_last_d;

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [31:0]       bursts_q,   bursts_d;

  // ---------------------------------------------------------------------------
  // Release / pop decisions
  // ---------------------------------------------------------------------------
  logic o_free;
  logic at_burst_max;
  logic timed_out;
  logic rel;
  logic rel_last;
  logic pop;

  always_comb begin
    o_free       = !o_valid_q || m_ready;
    at_burst_max = (beat_cnt_q == BEAT_MAX);
    timed_out    = (idle_cnt_q == IDLE_MAX);

    rel = h_valid_q && o_free &&
          (flush || at_burst_max || !fifo_empty || timed_out);

    // Priority flush > burst limit > next word present > timeout. Given that a
    // release is happening, the only way it is not a last beat is a waiting
    // follower word with neither flush nor the burst limit active, so the
    // flag reduces to the expression below.
    rel_last = flush || at_burst_max || fifo_empty;

    // H refills on the same edge it empties, so popping can keep one word per
    // cycle flowing. The reset term keeps the strobe quiet while the
    // registers are held in reset even if the FIFO already has data.
    pop = rst_n && !fifo_empty && (!h_valid_q || rel);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    h_valid_d  = h_valid_q;
    h_data_d   = h_data_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_last_d   = o_last_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    bursts_d   = bursts_q;

    // Hold register: a pop always wins because it replaces the word that is
    // being released on the same edge.
    if (pop) begin
      h_valid_d = 1'b1;
      h_data_d  = fifo_rd_data;
    end else if (rel) begin
      h_valid_d = 1'b0;
    end

    // Output register: loads on release, otherwise drains on handshake and
    // holds data/last stable under backpressure.
    if (rel) begin
      o_valid_d = 1'b1;
      o_data_d  = h_data_q;
      o_last_d  = rel_last;
    end else if (o_valid_q && m_ready) begin
      o_valid_d = 1'b0;
    end

    // Beat position inside the open burst; zero means no burst is open.
    if (rel) begin
      if (rel_last) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
    end

    // Idle counter only runs while a word is parked in H with nothing behind
    // it, and saturates so the timeout condition stays asserted until the
    // output register frees up.
    if (pop || rel) begin
      idle_cnt_d = '0;
    end else if (h_valid_q && fifo_empty && !timed_out) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (o_valid_q && m_ready && o_last_q) begin
      bursts_d = bursts_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_valid_q  <= 1'b0;
      h_data_q   <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      bursts_q   <= '0;
    end else begin
      h_valid_q  <= h_valid_d;
      h_data_q   <= h_data_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      bursts_q   <= bursts_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fifo_rd_en  = pop;
  assign m_valid     = o_valid_q;
  assign m_data      = o_data_q;
  assign m_last      = o_last_q;
  assign busy        = h_valid_q || o_valid_q;
  assign bursts_sent = bursts_q;

endmodule

// File: tb/tb_fifo_burst_drainer.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_burst_drainer (BURST_LEN=4, IDLE_TIMEOUT=16).
// A show-ahead FIFO is modelled with an array and pointers. A scoreboard keeps
// the words popped but not yet handed downstream. A per-cycle compare process
// checks busy, bursts_sent, beat order, stall stability, the burst length
// limit and reset values. Directed sequences pin latencies and last flags with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_fifo_burst_drainer;

  localparam int W  = 64;
  localparam int BL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          flush = 1'b0;
  logic          busy;
  logic [31:0]   bursts_sent;

  always #5 clk = ~clk;

  fifo_burst_drainer #(
    .WIDTH(W),
    .BURST_LEN(BL),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .flush(flush),
    .busy(busy),
    .bursts_sent(bursts_sent)
  );

  // Show-ahead FIFO model
  logic [W-1:0] mem [0:63];
  logic [5:0]   wr_ptr = 6'd0;
  logic [5:0]   rd_ptr = 6'd0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  task automatic push(input logic [W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Counters and comparison helper
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard (updated at the active edge)
  int           cyc = 0;
  logic [W-1:0] sb   [$];
  logic [W-1:0] hs_d [$];
  logic         hs_l [$];
  int           hs_c [$];
  int           rd_c [$];
  int           bidx = 0;
  logic [31:0]  exp_bursts = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      sb.delete();
      bidx       <= 0;
      exp_bursts <= 32'd0;
    end else begin
      if (m_valid && m_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        hs_d.push_back(m_data);
        hs_l.push_back(m_last);
        hs_c.push_back(cyc);
        if (m_last) begin
          bidx       <= 0;
          exp_bursts <= exp_bursts + 32'd1;
        end else begin
          bidx <= bidx + 1;
        end
      end
      if (fifo_rd_en) begin
        sb.push_back(fifo_rd_data);
        rd_c.push_back(cyc);
        rd_ptr <= rd_ptr + 6'd1;
      end
    end
  end

  // Per-cycle compare process (opposite edge)
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("reset m_valid", m_valid, 0);
      chk("reset m_data", m_data, 0);
      chk("reset m_last", m_last, 0);
      chk("reset busy", busy, 0);
      chk("reset bursts_sent", bursts_sent, 0);
      chk("reset fifo_rd_en", fifo_rd_en, 0);
      prev_stall = 1'b0;
    end else begin
      chk("busy vs outstanding words", busy, (sb.size() != 0));
      chk("bursts_sent", bursts_sent, exp_bursts);
      chk("rd_en while empty", fifo_rd_en & fifo_empty, 0);
      if (prev_stall) begin
        chk("stall m_valid", m_valid, 1);
        chk("stall m_data", m_data, prev_data);
        chk("stall m_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        chk("beat has popped source", (sb.size() != 0), 1);
        if (sb.size() != 0) chk("beat order", m_data, sb[0]);
        if (bidx == BL - 1) chk("last at burst limit", m_last, 1);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // Safe accessors for the logs
  function automatic logic [W-1:0] hsd(input int i);
    return (i < hs_d.size()) ? hs_d[i] : 'x;
  endfunction
  function automatic logic hsl(input int i);
    return (i < hs_l.size()) ? hs_l[i] : 1'bx;
  endfunction
  function automatic int hsc(input int i);
    return (i < hs_c.size()) ? hs_c[i] : -1000;
  endfunction
  function automatic int rdc(input int i);
    return (i < rd_c.size()) ? rd_c[i] : -5000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || !fifo_empty) && n < 200) begin
      step();
      n++;
    end
    chk("drain within budget", (n < 200), 1);
    step();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed sequences
  int hb;
  int rb;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // 1: eight preloaded words, BURST_LEN=4, m_ready=1
    step();
    step();
    hb = hs_d.size();
    rb = rd_c.size();
    for (int i = 0; i < 8; i++) push(64'h1000 + 64'(i));
    step();
    rst_n = 1'b1;
    drain();
    chk("t1 pop count", rd_c.size() - rb, 8);
    chk("t1 beat count", hs_d.size() - hb, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1 data", hsd(hb + i), 64'h1000 + 64'(i));
      chk("t1 last", hsl(hb + i), (i == 3 || i == 7));
      chk("t1 beat cycle", hsc(hb + i), rdc(rb) + 2 + i);
    end
    chk("t1 bursts_sent", bursts_sent, 2);

    // 2: three back-to-back words then idle timeout
    hb = hs_d.size();
    rb = rd_c.size();
    push(64'h2000);
    step();
    push(64'h2001);
    step();
    push(64'h2002);
    drain();
    chk("t2 beat count", hs_d.size() - hb, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2 data", hsd(hb + i), 64'h2000 + 64'(i));
      chk("t2 last", hsl(hb + i), (i == 2));
    end
    chk("t2 first beat latency", hsc(hb) - rdc(rb), 2);
    chk("t2 timeout latency", hsc(hb + 2) - rdc(rb + 2), TO + 2);
    chk("t2 bursts_sent", bursts_sent, 3);

    // 3: sixteen words with 10 cycles of backpressure
    hb = hs_d.size();
    rb = rd_c.size();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(64'h3000 + 64'(i));
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        chk("t3 stalled m_valid", m_valid, 1);
        chk("t3 stalled m_data", m_data, 64'h3000);
      end
      step();
    end
    chk("t3 pops under backpressure", rd_c.size() - rb, 2);
    m_ready = 1'b1;
    drain();
    chk("t3 beat count", hs_d.size() - hb, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3 data", hsd(hb + i), 64'h3000 + 64'(i));
      chk("t3 last", hsl(hb + i), ((i % 4) == 3));
      chk("t3 beat cycle", hsc(hb + i), hsc(hb) + i);
    end
    chk("t3 bursts_sent", bursts_sent, 7);

    // 4: single held word closed by a one-cycle flush at idle_cnt=3
    hb = hs_d.size();
    rb = rd_c.size();
    push(64'h4000);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain();
    chk("t4 beat count", hs_d.size() - hb, 1);
    chk("t4 data", hsd(hb), 64'h4000);
    chk("t4 last", hsl(hb), 1);
    chk("t4 flush latency", hsc(hb) - rdc(rb), 5);
    chk("t4 bursts_sent", bursts_sent, 8);

    // 5: next word arrives exactly as idle_cnt reaches the timeout
    hb = hs_d.size();
    rb = rd_c.size();
    push(64'h5000);
    repeat (17) step();
    push(64'h5001);
    drain();
    chk("t5 beat count", hs_d.size() - hb, 2);
    chk("t5 data0", hsd(hb), 64'h5000);
    chk("t5 last0", hsl(hb), 0);
    chk("t5 data1", hsd(hb + 1), 64'h5001);
    chk("t5 last1", hsl(hb + 1), 1);
    chk("t5 beat0 latency", hsc(hb) - rdc(rb), TO + 2);
    chk("t5 beat1 latency", hsc(hb + 1) - rdc(rb + 1), TO + 2);
    chk("t5 bursts_sent", bursts_sent, 9);

    // 6: reset with two beats sent and both stages full
    hb = hs_d.size();
    for (int i = 0; i < 4; i++) push(64'h6000 + 64'(i));
    repeat (4) step();
    m_ready = 1'b0;
    step();
    chk("t6 pre-reset m_valid", m_valid, 1);
    chk("t6 pre-reset busy", busy, 1);
    chk("t6 pre-reset m_data", m_data, 64'h6002);
    chk("t6 pre-reset beats", hs_d.size() - hb, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 async m_valid", m_valid, 0);
    chk("t6 async m_data", m_data, 0);
    chk("t6 async m_last", m_last, 0);
    chk("t6 async busy", busy, 0);
    chk("t6 async bursts_sent", bursts_sent, 0);
    for (int i = 0; i < 4; i++) push(64'h7000 + 64'(i));
    repeat (2) step();
    hb = hs_d.size();
    rst_n = 1'b1;
    m_ready = 1'b1;
    drain();
    chk("t6 beat count", hs_d.size() - hb, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t6 data", hsd(hb + i), 64'h7000 + 64'(i));
      chk("t6 last", hsl(hb + i), (i == 3));
    end
    chk("t6 bursts_sent", bursts_sent, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drainer.md
Name: fifo_burst_drainer

Overview:
- Read-side consumer for the synchronous show-ahead FIFO (read word visible while not empty, consumed by a read-enable pulse).
- Drains FIFO words and emits them as a valid/ready stream, framed into bursts with a last marker.
- A burst closes after BURST_LEN beats, on an idle timeout, or on flush.
- Sits between the trace FIFO and the downstream packetiser/DMA.

Parameters:
- WIDTH, 64, data word width; must match the FIFO width.
- BURST_LEN, 8, maximum beats per burst (>=1).
- IDLE_TIMEOUT, 16, idle cycles (>=1) before a held word is released as the burst end.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_rd_en  out  1  pop strobe to the FIFO; combinational.
- fifo_rd_data  in  WIDTH  FIFO head word (show-ahead).
- fifo_empty  in  1  FIFO empty flag.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  WIDTH  output beat data.
- m_last  out  1  final beat of the burst.
- flush  in  1  level; force-close the open burst.
- busy  out  1  hold or output register occupied.
- bursts_sent  out  32  count of completed bursts (last beat handshakes); wraps.

Behaviour:
- Reset (async, rst_n low): m_valid=0, m_data=0, m_last=0, busy=0, bursts_sent=0, beat_cnt=0, idle_cnt=0, h_valid=0. fifo_rd_en=0 while in reset. Reset mid-burst discards held and output words; the next word starts a new burst at beat 0.
- Two internal stages:
  - H (hold register, h_valid, h_data): one-word look-behind, so a word's last flag is decided only once the next word's arrival or absence is known.
  - O (output register): drives m_valid/m_data/m_last.
- o_free = !m_valid || m_ready.
- release (H->O at clock edge) = h_valid && o_free && (flush || beat_cnt==BURST_LEN-1 || !fifo_empty || idle_cnt==IDLE_TIMEOUT).
- Last flag priority on release:
  1. flush -> last=1.
  2. beat_cnt==BURST_LEN-1 -> last=1.
  3. !fifo_empty -> last=0.
  4. timeout -> last=1.
- fifo_rd_en = !fifo_empty && (!h_valid || release). It never asserts while fifo_empty=1. The popped fifo_rd_data is captured into H at the same edge; h_valid=1.
- Latency: a word popped at cycle t is in H at t+1 and on m_data at t+2 at the earliest (when the next word is already present).
- beat_cnt: +1 on each release with last=0; cleared to 0 on release with last=1.
- State view:
  - IDLE (beat_cnt=0) -> ACTIVE on first release with last=0.
  - ACTIVE -> IDLE on release with last=1.
  - A release with last=1 from IDLE is a single-beat burst.
- idle_cnt:
  - Cleared on pop or release.
  - Otherwise +1 while h_valid && fifo_empty, saturating at IDLE_TIMEOUT.
- O register: loads on release. If no release and m_ready && m_valid, m_valid->0. m_data/m_last hold stable while m_valid && !m_ready.
- bursts_sent: +1 on each cycle with m_valid && m_ready && m_last. Wraps at 2^32.
- busy = h_valid || m_valid.
- Backpressure: with m_ready=0 and O full, no release, so at most one further pop (into H) occurs. Pop resumes only when the H word is released.
- BURST_LEN=1: every word is released as soon as O is free, with last=1; no timeout wait.
- flush with h_valid=0 has no effect. flush never suppresses popping.

Test Plan:
1. BURST_LEN=4, FIFO preloaded with 8 words D0..D7, m_ready=1 -> 8 beats in order on consecutive cycles after a 2-cycle fill; m_last=1 on D3 and D7 only; bursts_sent=2; fifo_rd_en pulses exactly 8 times.
2. 3 words pushed back-to-back, then FIFO stays empty, IDLE_TIMEOUT=16 -> D0 and D1 with m_last=0. D2 m_valid rises IDLE_TIMEOUT+2=18 cycles after its fifo_rd_en cycle, with m_last=1; bursts_sent=1.
3. FIFO full with 16 words, m_ready=0 for 10 cycles -> exactly 2 pops; m_data=D0 stable, m_valid=1 throughout. After m_ready=1, remaining words stream 1 per cycle; no word lost or duplicated.
4. Single word held (idle_cnt=3), flush pulsed 1 cycle -> word appears next cycle with m_last=1; bursts_sent increments on handshake; beat_cnt=0.
5. FIFO becomes non-empty on the same cycle idle_cnt==IDLE_TIMEOUT -> held word released with m_last=0; burst continues; idle_cnt cleared.
6. rst_n asserted with a 2-beat-open burst and H/O full -> all outputs 0 immediately (async). After release, a new 4-word sequence with BURST_LEN=4 ends with m_last on the 4th word.
